vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/pixel_tick_div.sv | 44 ++++
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the 640x480@60 display path and small helpers
// used by the timing generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VIDEO  = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_VIDEO  = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam logic        DEF_SYNC_POL = 1'b0;

    localparam int unsigned DEF_H_TOTAL  = DEF_H_VIDEO + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_VIDEO + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned DEF_HS_START = DEF_H_VIDEO + DEF_H_FRONT;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_VS_START = DEF_V_VIDEO + DEF_V_FRONT;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    // Inclusive window test on a 10-bit raster coordinate.
    function automatic logic in_span(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Drives a sync line to its active level inside the window, idle level outside.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Clock-enable divider: asserts advance on every CLK_DIV-th system clock.
// Reusable by any block that steps at the pixel rate.
module pixel_tick_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic advance
);

    localparam int unsigned DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_div_check
        $error("pixel_tick_div: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] d_q;
    logic [DW-1:0] d_d;

    // Next divider count, wrapping at CLK_DIV-1.
    always_comb begin
        d_d = d_q;
        if (d_q == D_LAST) begin
            d_d = '0;
        end else begin
            d_d = d_q + DW'(1);
        end
    end

    // Divider state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign advance = (d_q == D_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with sync, video window and
// line/frame markers, all registered from the next counter values.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIDEO  = DEF_H_VIDEO,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_VIDEO  = DEF_V_VIDEO,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VIDEO + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VIDEO + V_FRONT + V_SYNC + V_BACK;

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VIDEO);
    localparam logic [10:0] V_VIS    = 11'(V_VIDEO);
    localparam logic [9:0]  HS_START = 10'(H_VIDEO + H_FRONT);
    localparam logic [9:0]  HS_END   = 10'(H_VIDEO + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  VS_START = 10'(V_VIDEO + V_FRONT);
    localparam logic [9:0]  VS_END   = 10'(V_VIDEO + V_FRONT + V_SYNC - 1);

    logic advance;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .advance (advance)
    );

    logic [9:0] pixel_x_q,     pixel_x_d;
    logic [9:0] pixel_y_q,     pixel_y_d;
    logic       video_on_q,    video_on_d;
    logic       hsync_q,       hsync_d;
    logic       vsync_q,       vsync_d;
    logic       pixel_tick_q,  pixel_tick_d;
    logic       line_start_q,  line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;

    // Next raster position and everything decoded from it, so outputs never
    // lag the counters they describe.
    always_comb begin
        pixel_x_d = pixel_x_q;
        pixel_y_d = pixel_y_q;
        if (advance) begin
            if (pixel_x_q == H_LAST) begin
                pixel_x_d = 10'd0;
                if (pixel_y_q == V_LAST) begin
                    pixel_y_d = 10'd0;
                end else begin
                    pixel_y_d = pixel_y_q + 10'd1;
                end
            end else begin
                pixel_x_d = pixel_x_q + 10'd1;
            end
        end else begin
            pixel_x_d = pixel_x_q;
        end

        video_on_d    = ({1'b0, pixel_x_d} < H_VIS) && ({1'b0, pixel_y_d} < V_VIS);
        hsync_d       = sync_level(in_span(pixel_x_d, HS_START, HS_END), SYNC_POL);
        vsync_d       = sync_level(in_span(pixel_y_d, VS_START, VS_END), SYNC_POL);
        pixel_tick_d  = advance;
        line_start_d  = advance && (pixel_x_d == 10'd0);
        frame_start_d = line_start_d && (pixel_y_d == 10'd0);

        if (frame_start_d) begin
            frame_count_d = frame_count_q + 8'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Output and counter registers; reset parks the raster on its last pixel
    // so the first advance lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x_q     <= H_LAST;
            pixel_y_q     <= V_LAST;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            pixel_tick_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pixel_tick_q  <= pixel_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_tick  = pixel_tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
